// File: rtl/dmem_arbiter_if.sv
// Bundle of core port (c_*), external loader port (x_*) and memory port (m_*) signals.
// The slave modport is the arbiter's view; master is the view of everything around it.
interface dmem_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          c_req;
  logic          c_we;
  logic [AW-1:0] c_addr;
  logic [DW-1:0] c_wdata;
  logic          c_stall;
  logic [DW-1:0] c_rdata;
  logic          c_rvalid;

  logic          x_req;
  logic          x_we;
  logic [AW-1:0] x_addr;
  logic [DW-1:0] x_wdata;
  logic          x_gnt;
  logic [DW-1:0] x_rdata;
  logic          x_rvalid;

  logic          m_en;
  logic          m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic [DW-1:0] m_rdata;

  modport slave (
    input  c_req, c_we, c_addr, c_wdata,
    output c_stall, c_rdata, c_rvalid,
    input  x_req, x_we, x_addr, x_wdata,
    output x_gnt, x_rdata, x_rvalid,
    output m_en, m_we, m_addr, m_wdata,
    input  m_rdata
  );

  modport master (
    output c_req, c_we, c_addr, c_wdata,
    input  c_stall, c_rdata, c_rvalid,
    output x_req, x_we, x_addr, x_wdata,
    input  x_gnt, x_rdata, x_rvalid,
    input  m_en, m_we, m_addr, m_wdata,
    output m_rdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Core-priority arbiter for a single-port data memory with a starvation slot for port X.
// Optional DMEM_ARB_PERF_EN adds perf_stall_cyc / perf_x_grants counters.
module dmem_arbiter #(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  dmem_arbiter_if.slave     bus
`ifdef DMEM_ARB_PERF_EN
  ,
  output logic [31:0]       perf_stall_cyc,
  output logic [31:0]       perf_x_grants
`endif
);

  typedef enum logic [1:0] {OWN_NONE, OWN_C, OWN_X} owner_t;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  logic [3:0] cnt_reg, cnt_next;
  owner_t     rd_owner_reg, rd_owner_next;
  logic       gnt_c, gnt_x;
  logic       c_stall;

  logic          m_en, m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_reg      <= 4'd0;
      rd_owner_reg <= OWN_NONE;
    end else begin
      cnt_reg      <= cnt_next;
      rd_owner_reg <= rd_owner_next;
    end
  end

  // No grants while reset is high, so a read in that window never gets an owner.
  always_comb begin
    gnt_c         = 1'b0;
    gnt_x         = 1'b0;
    cnt_next      = cnt_reg;
    rd_owner_next = OWN_NONE;
    if (!reset) begin
      if (bus.c_req && (!bus.x_req || (cnt_reg < STARVE_LIM)))
        gnt_c = 1'b1;
      else if (bus.x_req)
        gnt_x = 1'b1;
    end
    if (gnt_c) begin
      cnt_next = bus.x_req ? (cnt_reg + 4'd1) : 4'd0;
      if (!bus.c_we)
        rd_owner_next = OWN_C;
    end else if (gnt_x) begin
      cnt_next = 4'd0;
      if (!bus.x_we)
        rd_owner_next = OWN_X;
    end
  end

  always_comb begin
    m_en         = 1'b0;
    m_we         = 1'b0;
    m_addr       = '0;
    m_wdata      = '0;
    bus.c_rvalid = 1'b0;
    bus.c_rdata  = '0;
    bus.x_rvalid = 1'b0;
    bus.x_rdata  = '0;
    if (gnt_c) begin
      m_en    = 1'b1;
      m_we    = bus.c_we;
      m_addr  = bus.c_addr;
      m_wdata = bus.c_wdata;
    end else if (gnt_x) begin
      m_en    = 1'b1;
      m_we    = bus.x_we;
      m_addr  = bus.x_addr;
      m_wdata = bus.x_wdata;
    end
    c_stall = bus.c_req && !gnt_c && !reset;
    if (!reset && rd_owner_reg == OWN_C) begin
      bus.c_rvalid = 1'b1;
      bus.c_rdata  = bus.m_rdata;
    end
    if (!reset && rd_owner_reg == OWN_X) begin
      bus.x_rvalid = 1'b1;
      bus.x_rdata  = bus.m_rdata;
    end
  end

  assign bus.m_en    = m_en;
  assign bus.m_we    = m_we;
  assign bus.m_addr  = m_addr;
  assign bus.m_wdata = m_wdata;
  assign bus.c_stall = c_stall;
  assign bus.x_gnt   = gnt_x;

`ifdef DMEM_ARB_PERF_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_stall_cyc <= 32'd0;
      perf_x_grants  <= 32'd0;
    end else begin
      perf_stall_cyc <= perf_stall_cyc + {31'd0, c_stall};
      perf_x_grants  <= perf_x_grants + {31'd0, gnt_x};
    end
  end
`endif

endmodule
